sk6812_serializer: RTL and testbench

//  Frame engine downstream of the SK6812RGBW pixel RAM's second read port.
//  On a start pulse it walks pixel words 0..LED_COUNT-1 through rd_addr/rd_data,

---
 rtl/sk6812_serializer.sv | 135 +++++++++++++
 tb/tb_sk6812_serializer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/sk6812_serializer.sv
// SK6812RGBW frame engine: walks the pixel RAM through a registered read port and
// serialises each 32-bit {G,R,B,W} word MSB first, then holds the line low to latch.
module sk6812_serializer #(
    parameter int LED_COUNT = 35,
    parameter int ADDR_W    = 6,
    parameter int T0H_CYC   = 15,
    parameter int T1H_CYC   = 30,
    parameter int TBIT_CYC  = 63,
    parameter int TRST_CYC  = 4000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [31:0]       rd_data,
    output logic              led_dout
);
    localparam int BT_W = $clog2(TBIT_CYC);
    localparam int RT_W = $clog2(TRST_CYC);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_LOAD  = 3'd2;
    localparam logic [2:0] S_BIT   = 3'd3;
    localparam logic [2:0] S_LATCH = 3'd4;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(LED_COUNT - 1);
    localparam logic [ADDR_W-1:0] FIRST_PF  = (LED_COUNT > 1) ? ADDR_W'(1) : '0;
    localparam logic [BT_W-1:0]   TBIT_LAST = BT_W'(TBIT_CYC - 1);
    localparam logic [BT_W-1:0]   T0H       = BT_W'(T0H_CYC);
    localparam logic [BT_W-1:0]   T1H       = BT_W'(T1H_CYC);
    localparam logic [RT_W-1:0]   TRST_LAST = RT_W'(TRST_CYC - 1);

    logic [2:0]        r_state;
    logic              r_arm;
    logic              r_busy;
    logic              r_done;
    logic              r_led;
    logic [ADDR_W-1:0] r_rd_addr;
    logic [ADDR_W-1:0] r_pix_cnt;
    logic [31:0]       r_shift;
    logic [4:0]        r_bit_cnt;
    logic [BT_W-1:0]   r_bit_tmr;
    logic [RT_W-1:0]   r_rst_tmr;

    logic [BT_W-1:0]   w_th;
    logic              w_bit_end;
    logic              w_last_pix;
    logic [ADDR_W-1:0] w_addr_nxt;

    assign w_th       = r_shift[31] ? T1H : T0H;
    assign w_bit_end  = (r_bit_tmr == TBIT_LAST);
    assign w_last_pix = (r_pix_cnt == LAST_ADDR);
    // Prefetch saturates so the address never runs past the last pixel.
    assign w_addr_nxt = (r_rd_addr == LAST_ADDR) ? r_rd_addr : r_rd_addr + ADDR_W'(1);

    assign busy     = r_busy;
    assign done     = r_done;
    assign rd_addr  = r_rd_addr;
    assign led_dout = r_led;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_arm     <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_led     <= 1'b0;
            r_rd_addr <= '0;
            r_pix_cnt <= '0;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_bit_tmr <= '0;
            r_rst_tmr <= '0;
        end else begin
            // r_arm masks a start arriving in the first cycle after reset release.
            r_arm  <= 1'b1;
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_led  <= 1'b0;
                    r_busy <= 1'b0;
                    if (start && r_arm && !r_busy) begin
                        r_busy    <= 1'b1;
                        r_rd_addr <= '0;
                        r_state   <= S_FETCH;
                    end
                end
                S_FETCH: r_state <= S_LOAD;
                S_LOAD: begin
                    r_led     <= 1'b0;
                    r_shift   <= rd_data;
                    r_bit_cnt <= 5'd31;
                    r_pix_cnt <= '0;
                    r_bit_tmr <= '0;
                    r_rd_addr <= FIRST_PF;
                    r_state   <= S_BIT;
                end
                S_BIT: begin
                    r_led <= (r_bit_tmr < w_th);
                    if (!w_bit_end) begin
                        r_bit_tmr <= r_bit_tmr + BT_W'(1);
                    end else begin
                        r_bit_tmr <= '0;
                        if (r_bit_cnt != 5'd0) begin
                            r_shift   <= {r_shift[30:0], 1'b0};
                            r_bit_cnt <= r_bit_cnt - 5'd1;
                        end else if (!w_last_pix) begin
                            // Back-to-back words: next pixel was prefetched a full word ago.
                            r_shift   <= rd_data;
                            r_pix_cnt <= r_pix_cnt + ADDR_W'(1);
                            r_rd_addr <= w_addr_nxt;
                            r_bit_cnt <= 5'd31;
                        end else begin
                            r_rst_tmr <= '0;
                            r_state   <= S_LATCH;
                        end
                    end
                end
                S_LATCH: begin
                    r_led <= 1'b0;
                    if (r_rst_tmr == TRST_LAST) begin
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_rst_tmr <= r_rst_tmr + RT_W'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sk6812_serializer.sv
// Bench for sk6812_serializer: timeline model of the frame checked every cycle,
// plus a pulse decoder whose measurements are pinned to hand-computed values.
module tb_sk6812_serializer;
    localparam int L    = 11;
    localparam int AW   = 6;
    localparam int T0H  = 15;
    localparam int T1H  = 30;
    localparam int TBIT = 63;
    localparam int TRST = 4000;
    localparam int PIX  = 32 * TBIT;
    localparam int N    = L * PIX;
    localparam int FEND = N + 2 + TRST;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          busy, done, led_dout;
    logic [AW-1:0] rd_addr;
    logic [31:0]   rd_data = '0;
    logic [31:0]   ram [64];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    sk6812_serializer #(
        .LED_COUNT(L), .ADDR_W(AW), .T0H_CYC(T0H), .T1H_CYC(T1H),
        .TBIT_CYC(TBIT), .TRST_CYC(TRST)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .rd_addr(rd_addr), .rd_data(rd_data), .led_dout(led_dout)
    );

    always #5 clk = ~clk;

    // Registered read port of the pixel RAM; cyc is the index of the latest posedge.
    always @(posedge clk) begin
        cyc     <= cyc + 1;
        rd_data <= ram[rd_addr];
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s @cyc %0d: got %0h want %0h", nm, cyc, act, exp);
        end
    endtask

    // Timeline model: everything follows from the edge that accepted start.
    bit          armed = 0;
    bit          active = 0;
    int          start_cyc = 0;
    logic [31:0] ew [L];

    initial begin
        int n, k, p, b, c, ea, e;
        bit bv, eb, ed, el;
        forever begin
            @(posedge clk);
            #1;
            e = cyc;
            if (!rst_n) begin
                armed  = 0;
                active = 0;
            end else if (!armed) begin
                armed = 1;
            end else if (start && !(active && (e - 1 - start_cyc) <= FEND)) begin
                active    = 1;
                start_cyc = e;
            end
            eb = 0; ed = 0; el = 0; ea = 0;
            if (active) begin
                n = e - start_cyc;
                if (n >= 1 && (n - 1) % PIX == 0 && (n - 1) / PIX < L)
                    ew[(n - 1) / PIX] = ram[(n - 1) / PIX];
                eb = (n <= FEND);
                ed = (n == FEND);
                if (n >= 3 && n < 3 + N) begin
                    k  = n - 3;
                    p  = k / PIX;
                    b  = (k % PIX) / TBIT;
                    c  = k % TBIT;
                    bv = ew[p][31 - b];
                    el = (c < (bv ? T1H : T0H));
                end
                if (n >= 2) ea = ((n - 2) / PIX + 1 < L - 1) ? (n - 2) / PIX + 1 : L - 1;
            end
            chk("busy", busy, eb);
            chk("done", done, ed);
            chk("led", led_dout, el);
            chk("addr", rd_addr, ea);
        end
    end

    // Pulse decoder: rise times, high lengths and decoded bits of the line.
    int rise_q[$];
    int hl_q[$];
    bit bits_q[$];
    initial begin
        int hi;
        bit pl;
        hi = 0;
        pl = 0;
        forever begin
            @(posedge clk);
            #1;
            if (led_dout) begin
                hi = pl ? hi + 1 : 1;
                if (!pl) rise_q.push_back(cyc);
            end else if (pl) begin
                hl_q.push_back(hi);
                bits_q.push_back(hi > (T0H + T1H) / 2);
            end
            pl = led_dout;
        end
    end

    function automatic int qget(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    function automatic logic [31:0] word_at(input int p);
        logic [31:0] w;
        w = '0;
        for (int i = 0; i < 32; i++)
            if (p * 32 + i < bits_q.size()) w[31 - i] = bits_q[p * 32 + i];
        return w;
    endfunction

    initial begin
        int acc1, acc2, acc3, dcyc, hbad;
        logic [31:0] old3, new3, new5;
        bit was_high;

        for (int i = 0; i < 64; i++) ram[i] = $urandom;
        ram[0] = 32'h8000_0001;
        ram[1] = 32'h0000_0000;
        old3 = ram[3];
        new3 = ~ram[3];
        new5 = ~ram[5];

        // Frame 1: start held across the reset release edge is taken one cycle later.
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        start = 1'b1;
        @(negedge clk);
        @(negedge clk);
        start = 1'b0;
        acc1 = cyc;
        chk("accept_after_release", start_cyc, acc1);

        for (int i = 0; i < FEND + 100; i++) begin
            @(negedge clk);
            if (done) break;
            start = 1'($urandom_range(0, 1));
            if (i == 3 * PIX + 1000) begin
                ram[5] = new5;
                ram[3] = new3;
            end
        end
        chk("done_seen", done, 1);
        dcyc  = cyc;
        start = 1'b1;
        @(negedge clk);
        @(negedge clk);
        start = 1'b0;
        acc2 = cyc;

        chk("done_at", dcyc - acc1, 26178);
        chk("restart_gap", acc2 - dcyc, 2);
        chk("latency", qget(rise_q, 0) - acc1, 3);
        chk("hi_bit0", qget(hl_q, 0), 30);
        chk("hi_bit1", qget(hl_q, 1), 15);
        chk("hi_bit30", qget(hl_q, 30), 15);
        chk("hi_bit31", qget(hl_q, 31), 30);
        hbad = 0;
        for (int i = 32; i < 64; i++) if (qget(hl_q, i) != 15) hbad++;
        chk("pix1_hi_bad", hbad, 0);
        chk("period", qget(rise_q, 1) - qget(rise_q, 0), 63);
        chk("word_boundary", qget(rise_q, 32) - qget(rise_q, 31), 63);
        chk("nbits", hl_q.size(), 352);
        chk("word0", word_at(0), 32'h8000_0001);
        chk("word1", word_at(1), 32'h0);
        chk("word3_old", word_at(3), old3);
        chk("word5_new", word_at(5), new5);
        chk("latch_len", dcyc - (qget(rise_q, 351) + 63) + 1, 4000);

        // Frame 2: abandon it with reset in the high phase of a pixel-10 bit.
        repeat (10 * PIX + TBIT * $urandom_range(0, 30) + 5) @(negedge clk);
        for (int j = 0; j < 2 * TBIT && !led_dout; j++) @(posedge clk);
        @(posedge clk);
        #3;
        was_high = led_dout;
        chk("rst_led_was_high", was_high, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_led", led_dout, 0);
        chk("rst_busy", busy, 0);
        chk("rst_addr", rd_addr, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        rise_q.delete();
        hl_q.delete();
        bits_q.delete();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        acc3 = cyc;
        chk("restart_busy", busy, 1);
        repeat (3000) @(negedge clk);
        chk("restart_latency", qget(rise_q, 0) - acc3, 3);
        chk("restart_word0", word_at(0), 32'h8000_0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
